lap_memory: RTL and testbench
=============================

# lap_memory

Parametrised lap-record store for the stopwatch datapath. It sits between the key FSM and the LCD bridge. It captures up to DEPTH flattened BCD timestamps on `insert`, keeps a running best (minimum) lap, and offers a browsable read-out port. It also provides a multi-cycle `clear` with a `busy` handshake, matching how the FSM already treats the LCD's busy flag.

## Interface
- `DIGITS`, default 8: BCD digits per record; a record is 4*DIGITS bits, most-significant digit in the top nibble.
- `DEPTH`, default 8: number of record slots; must be at least 2.
- `OVERWRITE`, default 1: full-store policy. 1 overwrites the oldest slot; 0 drops the new record.
- `clock` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `insert` in 1: one-cycle pulse; store `record`.
- `record` in 4*DIGITS: timestamp to store, sampled on the `insert` cycle.
- `clear` in 1: one-cycle pulse; erase all slots and the best lap.
- `browse_prev` in 1: pulse; move the view one record older.
- `browse_next` in 1: pulse; move the view one record newer.
- `busy` out 1: high while clearing; `insert`, `clear` and browse inputs are ignored while it is high.
- `count` out clog2(DEPTH+1): number of valid records.
- `full` out 1: `count`==DEPTH.
- `empty` out 1: `count`==0.
- `dropped` out 1: one-cycle pulse when an insert is rejected.
- `view_record` out 4*DIGITS: record at the view position; 0 when `empty`.
- `view_index` out clog2(DEPTH): age of the viewed record, 0 = newest.
- `best_record` out 4*DIGITS: smallest record inserted since the last clear; all-ones when none.

## Operation
- Storage is a ring of DEPTH registers with a write pointer `wp` (next slot) and `count`.
- Reset state:
  - `wp`=0, `count`=0, `view_index`=0
  - `busy`=0, `dropped`=0
  - `view_record`=0, `best_record`=all-ones
  - FSM in IDLE
  - slot contents are don't-care.
- FSM states:
  - IDLE: accepts commands.
  - CLEARING: zeroes one slot per cycle, DEPTH cycles total.
- Transitions:
  - IDLE → CLEARING on `clear`. At that point `busy`=1 and `count`, `wp`, `view_index` go to 0, and `best_record` goes to all-ones.
  - CLEARING → IDLE after slot DEPTH-1 is written; `busy` drops the same cycle.
- Insert in IDLE, with `count`<DEPTH:
  - write `slot[wp]`
  - `wp` = (`wp`+1) mod DEPTH
  - `count`+1.
- Insert in IDLE, with `full` and OVERWRITE=1: write `slot[wp]`, the oldest slot, advance `wp`, and leave `count` at DEPTH.
- Insert in IDLE, with `full` and OVERWRITE=0: no write, and `dropped` pulses.
- Insert while `busy`: ignored, and `dropped` pulses.
- Any accepted insert resets `view_index` to 0, so the newest record is shown.
- Best lap: on an accepted insert, if `record` < `best_record` (unsigned compare; valid BCD orders the same as binary), then `best_record` = `record`.
  - An evicted record that was the best remains in `best_record`; best is cleared only by `clear` or `reset`.
- Browse:
  - `browse_prev` increments `view_index`, saturating at `count`-1.
  - `browse_next` decrements it, saturating at 0.
  - Both browse inputs in one cycle: no change.
  - Browse while `empty`: no change.
- View address = (`wp` - 1 - `view_index`) mod DEPTH.
- Simultaneous events:
  - `clear` beats `insert` and browse in the same cycle.
  - `insert` beats browse.
- `record` is stored as-is; non-BCD nibbles are not checked.

## Timing
- All outputs are registered.
- `count`, `full`, `empty` and `best_record` update on the cycle after an accepted `insert`.
- `view_record` reflects a new insert, browse or clear 1 cycle after the registered state change, i.e. 2 cycles after the input pulse.
- `dropped` is high exactly one cycle, the cycle after the rejected `insert`.
- `busy` rises the cycle after `clear` and stays high exactly DEPTH cycles.
- Back-to-back `insert` pulses on consecutive cycles are all accepted.
- `reset` asserted mid-clear aborts the clear and returns the block to reset state on the next edge.

## Test plan
- Basic: DEPTH=8, insert 0x00001234, then 0x00000999.
  - -> `count`=2.
  - -> `view_record`=0x00000999 at `view_index` 0.
  - -> after `browse_prev`, 0x00001234.
  - -> `best_record`=0x00000999.
- Overwrite: OVERWRITE=1, insert values 1..9.
  - -> `count`=8, `full`=1.
  - -> oldest viewable record (`view_index` 7) = 2.
  - -> `best_record`=1, which has been evicted.
- Drop: OVERWRITE=0, insert 1..9.
  - -> 9th insert gives a `dropped` pulse.
  - -> newest record stays 8; `count`=8.
- Clear handshake: after 3 records, pulse `clear`, then pulse `insert` 2 cycles later.
  - -> `busy` high 8 cycles.
  - -> the insert is dropped (`dropped` pulse).
  - -> `empty`=1, `view_record`=0, `best_record`=all-ones.
- Priority: `clear`+`insert` in the same cycle -> clear only, `count`=0.
  - `insert`+`browse_prev` in the same cycle -> `view_index`=0.
  - Both browse pulses together -> no move.
- Saturation and reset: with 3 records, `browse_prev` ×5 -> `view_index`=2.
  - Then assert `reset` mid-clear -> every output at its reset value the next cycle.

Source files
------------

// File: rtl/lap_memory.sv
// Lap-record store: ring of DEPTH BCD timestamps with running best lap,
// browsable read-out and a multi-cycle clear guarded by busy.
module lap_memory #(
    parameter int DIGITS    = 8,
    parameter int DEPTH     = 8,
    parameter int OVERWRITE = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         insert,
    input  logic [4*DIGITS-1:0]          record,
    input  logic                         clear,
    input  logic                         browse_prev,
    input  logic                         browse_next,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         dropped,
    output logic [4*DIGITS-1:0]          view_record,
    output logic [$clog2(DEPTH)-1:0]     view_index,
    output logic [4*DIGITS-1:0]          best_record
);

    localparam int W  = 4*DIGITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t        state;
    logic [W-1:0]  slots [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] clr_ptr;
    logic [PW-1:0] wp_next;
    logic [PW-1:0] view_addr;
    logic [PW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          accept;
    logic          wr_en;
    logic          browse_up;
    logic          browse_down;

    always_comb begin
        int unsigned addr_sum;
        wp_next = (wp == PW'(DEPTH-1)) ? '0 : wp + 1'b1;
        // Offset by DEPTH keeps the subtraction non-negative for any DEPTH.
        addr_sum  = 32'(wp) + 32'(DEPTH) - 32'd1 - 32'(view_index);
        view_addr = PW'(addr_sum % 32'(DEPTH));

        accept  = (state == IDLE) && !clear && insert && (!full || OVERWRITE != 0);
        wr_en   = accept || (state == CLEARING);
        wr_addr = (state == CLEARING) ? clr_ptr : wp;
        wr_data = (state == CLEARING) ? '0 : record;

        browse_up   = browse_prev && !browse_next && !empty &&
                      (CW'(view_index) < (count - 1'b1));
        browse_down = browse_next && !browse_prev && (view_index != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en)
            slots[wr_addr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            dropped     <= 1'b0;
            wp          <= '0;
            clr_ptr     <= '0;
            view_index  <= '0;
            view_record <= '0;
            best_record <= '1;
        end else begin
            dropped     <= 1'b0;
            view_record <= empty ? '0 : slots[view_addr];
            case (state)
                IDLE: begin
                    if (clear) begin
                        state       <= CLEARING;
                        busy        <= 1'b1;
                        count       <= '0;
                        full        <= 1'b0;
                        empty       <= 1'b1;
                        wp          <= '0;
                        clr_ptr     <= '0;
                        view_index  <= '0;
                        best_record <= '1;
                    end else if (insert) begin
                        // A rejected insert still blocks browsing this cycle.
                        if (accept) begin
                            wp         <= wp_next;
                            view_index <= '0;
                            if (!full) begin
                                count <= count + 1'b1;
                                empty <= 1'b0;
                                full  <= (count == CW'(DEPTH-1));
                            end
                            if (record < best_record)
                                best_record <= record;
                        end else begin
                            dropped <= 1'b1;
                        end
                    end else if (browse_up) begin
                        view_index <= view_index + 1'b1;
                    end else if (browse_down) begin
                        view_index <= view_index - 1'b1;
                    end
                end
                CLEARING: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == PW'(DEPTH-1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    if (insert)
                        dropped <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lap_memory.sv
// Self-checking bench for lap_memory: two instances (overwrite and drop policy)
// driven in lockstep and compared against a list-based reference model.
module tb_lap_memory;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        insert = 1'b0;
    logic [31:0] record = '0;
    logic        clear = 1'b0;
    logic        browse_prev = 1'b0;
    logic        browse_next = 1'b0;

    logic        o_busy [2];
    logic [3:0]  o_count [2];
    logic        o_full [2];
    logic        o_empty [2];
    logic        o_drop [2];
    logic [31:0] o_view [2];
    logic [2:0]  o_vi [2];
    logic [31:0] o_best [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lap_memory #(.DIGITS(8), .DEPTH(8), .OVERWRITE(1)) dut_ow (
        .clock(clock), .reset(reset), .insert(insert), .record(record),
        .clear(clear), .browse_prev(browse_prev), .browse_next(browse_next),
        .busy(o_busy[0]), .count(o_count[0]), .full(o_full[0]), .empty(o_empty[0]),
        .dropped(o_drop[0]), .view_record(o_view[0]), .view_index(o_vi[0]),
        .best_record(o_best[0]));

    lap_memory #(.DIGITS(8), .DEPTH(8), .OVERWRITE(0)) dut_dr (
        .clock(clock), .reset(reset), .insert(insert), .record(record),
        .clear(clear), .browse_prev(browse_prev), .browse_next(browse_next),
        .busy(o_busy[1]), .count(o_count[1]), .full(o_full[1]), .empty(o_empty[1]),
        .dropped(o_drop[1]), .view_record(o_view[1]), .view_index(o_vi[1]),
        .best_record(o_best[1]));

    // Reference model: list index 0 = oldest record, mn entries valid.
    // Model 0 overwrites when full, model 1 drops.
    logic [31:0] ml [2][8];
    int          mn [2];
    int          mvi [2];
    int          mbl [2];
    logic [31:0] mbest [2];
    logic [31:0] mview [2];
    logic        mdrop [2];

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] pre;
            pre = (mn[k] == 0) ? 32'd0 : ml[k][mn[k]-1-mvi[k]];
            mdrop[k] = 1'b0;
            if (reset) begin
                mn[k] = 0; mvi[k] = 0; mbl[k] = 0;
                mbest[k] = '1; mview[k] = '0;
            end else begin
                mview[k] = pre;
                if (mbl[k] > 0) begin
                    mbl[k]--;
                    if (insert) mdrop[k] = 1'b1;
                end else if (clear) begin
                    mn[k] = 0; mvi[k] = 0; mbl[k] = 8; mbest[k] = '1;
                end else if (insert) begin
                    if (mn[k] < 8 || k == 0) begin
                        if (mn[k] < 8) begin
                            ml[k][mn[k]] = record;
                            mn[k]++;
                        end else begin
                            for (int j = 0; j < 7; j++) ml[k][j] = ml[k][j+1];
                            ml[k][7] = record;
                        end
                        mvi[k] = 0;
                        if (record < mbest[k]) mbest[k] = record;
                    end else begin
                        mdrop[k] = 1'b1;
                    end
                end else if (browse_prev && !browse_next) begin
                    if (mn[k] > 0 && mvi[k] < mn[k]-1) mvi[k]++;
                end else if (browse_next && !browse_prev) begin
                    if (mvi[k] > 0) mvi[k]--;
                end
            end
        end
    endtask

    task automatic cycle(input logic i, input logic [31:0] r, input logic c,
                         input logic p, input logic n);
        insert = i; record = r; clear = c; browse_prev = p; browse_next = n;
        @(posedge clock);
        model_edge();
        #1;
        insert = 1'b0; clear = 1'b0; browse_prev = 1'b0; browse_next = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((o_busy[0] || o_busy[1]) && t < 20) begin
            idle(1);
            t++;
        end
        checks++;
        if (o_busy[0] || o_busy[1]) begin
            errors++;
            $display("FAIL busy_timeout got busy=%b/%b want 0 within 20 cycles", o_busy[0], o_busy[1]);
        end
        idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({o_busy[k], o_count[k], o_full[k], o_empty[k], o_drop[k], o_vi[k]} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d got %b want %b", k,
                    {o_busy[k], o_count[k], o_full[k], o_empty[k], o_drop[k], o_vi[k]}, 11'b0_0000_0_1_0_000);
            end
            checks++;
            if (o_view[k] !== 32'd0 || o_best[k] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL reset_data dut%0d got view=%h best=%h want 0/ffffffff", k, o_view[k], o_best[k]);
            end
        end
    endtask

    task automatic test_basic();
        cycle(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0999, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_count[k] !== 4'd2 || o_view[k] !== 32'h0000_0999 || o_vi[k] !== 3'd0) begin
                errors++;
                $display("FAIL basic_newest dut%0d got count=%0d view=%h idx=%0d want 2/00000999/0",
                    k, o_count[k], o_view[k], o_vi[k]);
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_view[k] !== 32'h0000_1234 || o_best[k] !== 32'h0000_0999) begin
                errors++;
                $display("FAIL basic_prev dut%0d got view=%h best=%h want 00001234/00000999",
                    k, o_view[k], o_best[k]);
            end
        end
    endtask

    task automatic test_overwrite();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        for (int v = 1; v <= 9; v++) begin
            cycle(1'b1, 32'(v), 1'b0, 1'b0, 1'b0);
            if (v == 9) begin
                checks++;
                if (o_drop[0] !== 1'b0 || o_drop[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_pulse got ow=%b dr=%b want 0/1", o_drop[0], o_drop[1]);
                end
            end
        end
        idle(1);
        checks++;
        if (o_drop[1] !== 1'b0) begin
            errors++;
            $display("FAIL drop_one_cycle got %b want 0", o_drop[1]);
        end
        checks++;
        if (o_view[1] !== 32'd8 || o_count[1] !== 4'd8) begin
            errors++;
            $display("FAIL drop_newest got view=%h count=%0d want 8/8", o_view[1], o_count[1]);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        checks++;
        if (o_count[0] !== 4'd8 || o_full[0] !== 1'b1 || o_vi[0] !== 3'd7 || o_view[0] !== 32'd2 || o_best[0] !== 32'd1) begin
            errors++;
            $display("FAIL overwrite_oldest got count=%0d full=%b idx=%0d view=%h best=%h want 8/1/7/2/1",
                o_count[0], o_full[0], o_vi[0], o_view[0], o_best[0]);
        end
        checks++;
        if (o_view[1] !== mview[1] || o_vi[1] !== 3'(mvi[1])) begin
            errors++;
            $display("FAIL drop_oldest got view=%h idx=%0d want %h/%0d", o_view[1], o_vi[1], mview[1], mvi[1]);
        end
    endtask

    task automatic test_clear_handshake();
        int busy_cycles;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        for (int v = 0; v < 3; v++) cycle(1'b1, 32'h100 + 32'(v), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        busy_cycles = o_busy[0] ? 1 : 0;
        idle(1);
        busy_cycles += o_busy[0] ? 1 : 0;
        cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        busy_cycles += o_busy[0] ? 1 : 0;
        checks++;
        if (o_drop[0] !== 1'b1 || o_drop[1] !== 1'b1) begin
            errors++;
            $display("FAIL clear_insert_drop got %b/%b want 1/1", o_drop[0], o_drop[1]);
        end
        for (int t = 0; t < 20 && o_busy[0]; t++) begin
            idle(1);
            busy_cycles += o_busy[0] ? 1 : 0;
        end
        checks++;
        if (busy_cycles !== 8) begin
            errors++;
            $display("FAIL clear_busy_len got %0d want 8", busy_cycles);
        end
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_empty[k] !== 1'b1 || o_view[k] !== 32'd0 || o_best[k] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL clear_state dut%0d got empty=%b view=%h best=%h want 1/0/ffffffff",
                    k, o_empty[k], o_view[k], o_best[k]);
            end
        end
    endtask

    task automatic test_priority();
        cycle(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h43, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_count[0] !== 4'd0 || o_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL prio_clear_insert got count=%0d busy=%b want 0/1", o_count[0], o_busy[0]);
        end
        wait_idle();
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h12, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_vi[0] !== 3'd0 || o_count[0] !== 4'd3) begin
            errors++;
            $display("FAIL prio_insert_browse got idx=%0d count=%0d want 0/3", o_vi[0], o_count[0]);
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (o_vi[0] !== 3'd1) begin
            errors++;
            $display("FAIL prio_both_browse got idx=%0d want 1", o_vi[0]);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_vi[0] !== 3'd0) begin
            errors++;
            $display("FAIL browse_next_sat got idx=%0d want 0", o_vi[0]);
        end
    endtask

    task automatic test_saturation_reset();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        for (int v = 0; v < 3; v++) cycle(1'b1, 32'h200 + 32'(v), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        checks++;
        if (o_vi[0] !== 3'd2 || o_view[0] !== 32'h200) begin
            errors++;
            $display("FAIL browse_prev_sat got idx=%0d view=%h want 2/00000200", o_vi[0], o_view[0]);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({o_busy[k], o_count[k], o_full[k], o_empty[k], o_drop[k], o_vi[k], o_view[k], o_best[k]} !==
                {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'hFFFF_FFFF}) begin
                errors++;
                $display("FAIL reset_midclear dut%0d got busy=%b count=%0d full=%b empty=%b drop=%b idx=%0d view=%h best=%h",
                    k, o_busy[k], o_count[k], o_full[k], o_empty[k], o_drop[k], o_vi[k], o_view[k], o_best[k]);
            end
        end
        idle(2);
        checks++;
        if (o_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b want 0", o_busy[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int unsigned op;
            logic [31:0] r;
            op = $urandom_range(0, 99);
            r  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 'h9999));
            cycle(op < 40, r, op == 99 || op == 98,
                  (op >= 40 && op < 65) || op == 90 || op == 41,
                  (op >= 65 && op < 88) || op == 90 || op == 10);
            for (int k = 0; k < 2; k++) begin
                logic [74:0] got, exp;
                got = {o_busy[k], o_count[k], o_full[k], o_empty[k], o_drop[k], o_vi[k], o_view[k], o_best[k]};
                exp = {mbl[k] > 0, 4'(mn[k]), mn[k] == 8, mn[k] == 0, mdrop[k], 3'(mvi[k]), mview[k], mbest[k]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_c%0d dut%0d got %h want %h", c, k, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overwrite();
        test_clear_handshake();
        test_priority();
        test_saturation_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
